// File: rtl/traffic_phase_sched.sv
// Two-direction traffic phase scheduler with pedestrian walk grants and emergency preemption.
// Lamps and walk outputs are a Moore decode of the state register.
module traffic_phase_sched #(
   parameter int GREEN_T  = 25,
   parameter int YELLOW_T = 5,
   parameter int CLEAR_T  = 2,
   parameter int WALK_T   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       emg,
   input  logic       ped_a,
   input  logic       ped_b,
   output logic [2:0] A,
   output logic [2:0] B,
   output logic       walk_a,
   output logic       walk_b,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      CLR_B   = 3'd0,
      A_GRN   = 3'd1,
      A_YEL   = 3'd2,
      CLR_A   = 3'd3,
      B_GRN   = 3'd4,
      B_YEL   = 3'd5,
      PREEMPT = 3'd6
   } state_t;

   localparam logic [7:0] GREEN_C  = 8'(GREEN_T);
   localparam logic [7:0] YELLOW_C = 8'(YELLOW_T);
   localparam logic [7:0] CLEAR_C  = 8'(CLEAR_T);
   localparam logic [7:0] WALK_C   = 8'(WALK_T);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_G = 3'b010;
   localparam logic [2:0] LAMP_Y = 3'b001;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic [7:0] dur;
   logic       expire;
   logic       pre_emg;
   logic       pend_a;
   logic       pend_b;
   logic       grant_a;
   logic       grant_b;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dur = CLEAR_C;
      case (state)
         A_GRN, B_GRN: dur = GREEN_C;
         A_YEL, B_YEL: dur = YELLOW_C;
         default:      dur = CLEAR_C;
      endcase
   end

   assign expire = tick && (cnt == dur - 8'd1);

   // pre_emg remembers an emergency seen before the final yellow edge, so yellow always runs its full length.
   always_comb begin
      state_nxt = state;
      case (state)
         CLR_B: begin
            if (emg)         state_nxt = PREEMPT;
            else if (expire) state_nxt = A_GRN;
         end
         A_GRN: begin
            if (emg || expire) state_nxt = A_YEL;
         end
         A_YEL: begin
            if (expire) state_nxt = pre_emg ? PREEMPT : CLR_A;
         end
         CLR_A: begin
            if (emg)         state_nxt = PREEMPT;
            else if (expire) state_nxt = B_GRN;
         end
         B_GRN: begin
            if (emg || expire) state_nxt = B_YEL;
         end
         B_YEL: begin
            if (expire) state_nxt = pre_emg ? PREEMPT : CLR_B;
         end
         PREEMPT: begin
            if (!emg) state_nxt = CLR_B;
         end
         default: state_nxt = CLR_B;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLR_B;
         cnt     <= '0;
         pre_emg <= 1'b0;
         pend_a  <= 1'b0;
         pend_b  <= 1'b0;
         grant_a <= 1'b0;
         grant_b <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= (state_nxt != state) ? 8'd0 : cnt + {7'd0, tick};
         pre_emg <= ((state_nxt == A_YEL) || (state_nxt == B_YEL)) && (pre_emg || emg);

         if ((state_nxt == A_GRN) && (state != A_GRN)) begin
            grant_a <= pend_a || ped_a;
            pend_a  <= 1'b0;
         end else if (ped_a) begin
            pend_a  <= 1'b1;
         end

         if ((state_nxt == B_GRN) && (state != B_GRN)) begin
            grant_b <= pend_b || ped_b;
            pend_b  <= 1'b0;
         end else if (ped_b) begin
            pend_b  <= 1'b1;
         end
      end
   end

   always_comb begin
      A      = LAMP_R;
      B      = LAMP_R;
      walk_a = 1'b0;
      walk_b = 1'b0;
      phase  = state;
      case (state)
         A_GRN: begin
            A      = LAMP_G;
            walk_a = grant_a && (cnt < WALK_C);
         end
         A_YEL: A = LAMP_Y;
         B_GRN: begin
            B      = LAMP_G;
            walk_b = grant_b && (cnt < WALK_C);
         end
         B_YEL: B = LAMP_Y;
         default: begin
            A = LAMP_R;
            B = LAMP_R;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched with GREEN_T=4, YELLOW_T=2, CLEAR_T=1, WALK_T=2.
// Outputs are sampled 1 time unit after the rising edge.
module tb_traffic_phase_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       emg;
   logic       ped_a;
   logic       ped_b;
   logic [2:0] A;
   logic [2:0] B;
   logic       walk_a;
   logic       walk_b;
   logic [2:0] phase;

   int n_vec = 0;
   int n_err = 0;

   int norm_seq [14] = '{0, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5};
   int durs [6]      = '{1, 4, 2, 1, 4, 2};
   int slow_q [$];
   int a_grn_clks;

   traffic_phase_sched #(
      .GREEN_T (4),
      .YELLOW_T(2),
      .CLEAR_T (1),
      .WALK_T  (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .emg   (emg),
      .ped_a (ped_a),
      .ped_b (ped_b),
      .A     (A),
      .B     (B),
      .walk_a(walk_a),
      .walk_b(walk_b),
      .phase (phase)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] exp_out(input int ph, input bit wa, input bit wb);
      logic [2:0] ea;
      logic [2:0] eb;
      case (ph)
         1:       begin ea = 3'b010; eb = 3'b100; end
         2:       begin ea = 3'b001; eb = 3'b100; end
         4:       begin ea = 3'b100; eb = 3'b010; end
         5:       begin ea = 3'b100; eb = 3'b001; end
         default: begin ea = 3'b100; eb = 3'b100; end
      endcase
      return {ea, eb, wa, wb, 3'(ph)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Compares {A,B,walk_a,walk_b,phase} against the lamp table for the expected phase.
   task automatic out_chk(input string tag, input int ph, input bit wa, input bit wb);
      check(tag, {21'd0, A, B, walk_a, walk_b, phase}, {21'd0, exp_out(ph, wa, wb)});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag, input int ph, input bit wa, input bit wb);
      step();
      out_chk(tag, ph, wa, wb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      tick  = 1'b0;
      emg   = 1'b0;
      ped_a = 1'b0;
      ped_b = 1'b0;

      #3;
      out_chk("reset_state", 0, 0, 0);
      step();
      rst = 1'b0;
      out_chk("reset_release", 0, 0, 0);

      // Normal cycle, tick every clk: period 14.
      tick = 1'b1;
      for (int k = 1; k <= 28; k++)
         step_chk($sformatf("norm[%0d]", k), norm_seq[k % 14], 0, 0);

      // Tick every third clk: each state lasts DUR ticks = 3*DUR clks.
      for (int s = 0; s < 6; s++)
         for (int r = 0; r < durs[s] * 3; r++)
            slow_q.push_back(s);
      slow_q.push_back(0);
      a_grn_clks = 0;
      out_chk("slow[0]", slow_q[0], 0, 0);
      for (int k = 1; k <= 42; k++) begin
         tick = (k % 3 == 0);
         step_chk($sformatf("slow[%0d]", k), slow_q[k], 0, 0);
         if (phase == 3'd1) a_grn_clks++;
      end
      check("slow_a_grn_clks", 32'(a_grn_clks), 32'd12);

      // Pedestrian A: pulse during B_GRN, then a pulse on the A_GRN entry edge.
      tick = 1'b1;
      for (int k = 1; k <= 43; k++) begin
         ped_a = (k == 9) || (k == 29);
         step();
         ped_a = 1'b0;
         out_chk($sformatf("ped[%0d]", k), norm_seq[k % 14],
                 (k == 15) || (k == 16) || (k == 29) || (k == 30), 0);
      end

      // Emergency in A_GRN at counter 1, applied on a clk without tick.
      step_chk("emg_agrn_cnt1", 1, 0, 0);
      emg  = 1'b1;
      tick = 1'b0;
      step_chk("emg_to_yel", 2, 0, 0);
      tick = 1'b1;
      step_chk("emg_yel_tick2", 2, 0, 0);
      step_chk("emg_preempt", 6, 0, 0);
      for (int k = 0; k < 3; k++)
         step_chk($sformatf("emg_hold[%0d]", k), 6, 0, 0);
      emg = 1'b0;
      step_chk("emg_exit_clrb", 0, 0, 0);
      step_chk("emg_then_agrn", 1, 0, 0);

      // Emergency on the B_YEL->CLR_B edge, ped_b during PREEMPT.
      for (int k = 2; k <= 13; k++)
         step_chk($sformatf("sim_run[%0d]", k), norm_seq[k], 0, 0);
      emg = 1'b1;
      step_chk("sim_clrb", 0, 0, 0);
      step_chk("sim_preempt", 6, 0, 0);
      ped_b = 1'b1;
      step_chk("pre_ped_b", 6, 0, 0);
      ped_b = 1'b0;
      step_chk("pre_hold", 6, 0, 0);
      emg = 1'b0;
      step_chk("pre_exit", 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         ped_a = (k == 9);
         step();
         ped_a = 1'b0;
         out_chk($sformatf("walk_b[%0d]", k), norm_seq[k], 0, (k == 8) || (k == 9));
      end

      // Asynchronous reset mid B_GRN, then restart from CLR_B with pend_a discarded.
      #2;
      rst = 1'b1;
      #1;
      out_chk("rst_async", 0, 0, 0);
      step_chk("rst_held_edge", 0, 0, 0);
      rst = 1'b0;
      for (int k = 1; k <= 14; k++)
         step_chk($sformatf("restart[%0d]", k), norm_seq[k % 14], 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/traffic_phase_sched.md
TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 SHALL provide parameter GREEN_T, default 25, green phase length in ticks.
REQ-002 SHALL provide parameter YELLOW_T, default 5, yellow phase length in ticks.
REQ-003 SHALL provide parameter CLEAR_T, default 2, all-red clearance length in ticks.
REQ-004 SHALL provide parameter WALK_T, default 10, walk grant length in ticks; legal range 1 <= WALK_T < GREEN_T, all parameters 1..255.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-007 SHALL have port tick  input  1  one-clk timebase strobe (1 Hz nominal).
REQ-008 SHALL have port emg  input  1  emergency preempt request, level.
REQ-009 SHALL have port ped_a  input  1  pedestrian request pulse for the A-green walk phase.
REQ-010 SHALL have port ped_b  input  1  pedestrian request pulse for the B-green walk phase.
REQ-011 SHALL have port A  output  3  direction-A lamps {R,G,Y}.
REQ-012 SHALL have port B  output  3  direction-B lamps {R,G,Y}.
REQ-013 SHALL have port walk_a, walk_b  output  1 each  walk lamps.
REQ-014 SHALL have port phase  output  3  current state code.

Function
REQ-015 SHALL implement states CLR_B=0, A_GRN=1, A_YEL=2, CLR_A=3, B_GRN=4, B_YEL=5, PREEMPT=6.
REQ-016 SHALL drive lamps as Moore decode of the state register, with no extra latency: A_GRN A=010 B=100; A_YEL A=001 B=100; B_GRN A=100 B=010; B_YEL A=100 B=001; CLR_A, CLR_B and PREEMPT A=B=100; phase equals the state code.
REQ-017 SHALL keep an 8-bit dwell counter that increments only on clk edges with tick=1 and clears to 0 on every state change.
REQ-018 SHALL, when tick=1 and counter==DUR-1, change state at that clk edge with the normal sequence CLR_B->A_GRN->A_YEL->CLR_A->B_GRN->B_YEL->CLR_B (DUR is GREEN_T, YELLOW_T or CLEAR_T per state), so each state lasts exactly DUR ticks.
REQ-019 SHALL latch ped_a into pend_a and ped_b into pend_b on any clk where the input is 1.
REQ-020 SHALL, on entry to A_GRN, grant a walk if pend_a|ped_a, then clear pend_a; same for B_GRN with pend_b|ped_b; a request on any later cycle stays pending for the next green.
REQ-021 SHALL hold walk_a=1 during A_GRN while a walk is granted and counter<WALK_T, else 0; walk_b behaves the same in B_GRN; both are 0 in all other states.
REQ-022 SHALL, with emg=1 in A_GRN or B_GRN, move to the matching yellow at the next clk regardless of tick or counter.
REQ-023 SHALL, with emg=1 in a yellow state, complete the full YELLOW_T and then enter PREEMPT instead of the clearance state.
REQ-024 SHALL, with emg=1 in CLR_A or CLR_B, enter PREEMPT at the next clk.
REQ-025 SHALL remain in PREEMPT while emg=1, and on the first clk with emg=0 go to CLR_B with counter 0, after which A_GRN follows.
REQ-026 SHALL keep pend_a and pend_b latched through PREEMPT; walk grants are never issued in PREEMPT.
REQ-027 SHALL, if the state register holds an illegal code, go to CLR_B at the next clk with all lamps red.

Reset
REQ-028 SHALL, on rst=1, immediately force: state CLR_B, counter 0, pend_a=pend_b=0, walk grants cleared, A=B=100, walk_a=walk_b=0, phase=0.
REQ-029 SHALL restart the normal sequence from CLR_B when rst is released mid-phase; no partial phase resumes.

Verification
All scenarios use GREEN_T=4, YELLOW_T=2, CLEAR_T=1, WALK_T=2 unless stated.
REQ-030 SHALL cover the normal cycle: tick=1 every clk after reset -> phase 0,1x4,2x2,3,4x4,5x2,0 and repeats with a period of 14 clks.
REQ-031 SHALL cover tick every 3rd clk -> each state lasts exactly DUR ticks (A_GRN = 12 clks).
REQ-032 SHALL cover a pedestrian request: ped_a pulse during B_GRN -> walk_a=1 for the first 2 ticks of the next A_GRN and walk_b stays 0; ped_a on the A_GRN entry clk is also granted.
REQ-033 SHALL cover emergency: emg=1 at A_GRN counter=1 -> A_YEL the next clk, 2 ticks of yellow, then PREEMPT with A=B=100 held; drop emg -> CLR_B, then A_GRN.
REQ-034 SHALL cover simultaneous events: emg asserted on the same clk as a tick-driven B_YEL->CLR_B transition -> CLR_B then PREEMPT; a ped_b pulse during PREEMPT is granted in the next B_GRN.
REQ-035 SHALL cover rst asserted mid B_GRN -> outputs all red and phase=0 asynchronously, before the next clk edge.
